// File: rtl/xyolo_read_mc_pkg.sv
// Shared definitions for the xyolo_read_mc weight reader: config register map,
// FSM state encodings and config field-width helpers.
package xyolo_read_mc_pkg;

   // Config register addresses on the 4-bit CPU write port.
   localparam logic [3:0] CFG_EXT_ADDR = 4'd0;
   localparam logic [3:0] CFG_OFFSET   = 4'd1;
   localparam logic [3:0] CFG_LEN_A    = 4'd2;
   localparam logic [3:0] CFG_CH_MASK  = 4'd3;
   localparam logic [3:0] CFG_ITER_B   = 4'd4;
   localparam logic [3:0] CFG_PER_B    = 4'd5;
   localparam logic [3:0] CFG_START_B  = 4'd6;
   localparam logic [3:0] CFG_SHIFT_B  = 4'd7;
   localparam logic [3:0] CFG_INCR_B   = 4'd8;

   // Per-channel fill sequencer.
   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_REQ,
      FILL_DONE
   } fill_state_t;

   // Top-level run state; done is high only in TOP_IDLE.
   typedef enum logic {
      TOP_IDLE,
      TOP_BUSY
   } top_state_t;

   // OFFSET keeps the low half of the external address width.
   function automatic int offset_w(input int io_addr_w);
      return io_addr_w / 2;
   endfunction

   // LEN_A is one bit wider than a bank index so a full bank can be filled.
   function automatic int len_w(input int mem_addr_w);
      return mem_addr_w;
   endfunction

   // START/SHIFT/INCR address one bank; the bank bit is added separately.
   function automatic int bank_addr_w(input int mem_addr_w);
      return mem_addr_w - 1;
   endfunction

endpackage

// File: rtl/xyolo_read_mc_ch.sv
// One weight channel: bus fill sequencer, two-bank weight memory with a
// one-cycle registered read port, and one bias register per bank.
module xyolo_read_mc_ch
   import xyolo_read_mc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int IO_ADDR_W  = 32,
   parameter int MEM_ADDR_W = 11
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  enable,
   input  logic [IO_ADDR_W-1:0]  base,
   input  logic [MEM_ADDR_W-1:0] len,
   input  logic                  fill_bank,
   output logic                  bus_valid,
   input  logic                  bus_ready,
   output logic [IO_ADDR_W-1:0]  bus_addr,
   input  logic [DATA_W-1:0]     bus_rdata,
   input  logic                  rd_en,
   input  logic [MEM_ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  bias_bank,
   output logic [DATA_W-1:0]     bias,
   output logic                  fill_done
);

   localparam logic [IO_ADDR_W-1:0] STEP = IO_ADDR_W'(DATA_W / 8);

   fill_state_t           state, state_nxt;
   logic [IO_ADDR_W-1:0]  addr_q;
   logic [MEM_ADDR_W-1:0] k_q;
   logic [MEM_ADDR_W-1:0] len_q;
   logic                  bank_q;
   logic [DATA_W-1:0]     bias_q [2];
   logic [DATA_W-1:0]     mem [2**MEM_ADDR_W];
   logic                  beat;

   // A word is taken on every cycle the request is held and the bus accepts it.
   assign beat     = (state == FILL_REQ) && bus_ready;
   assign bus_addr = addr_q;
   assign bias     = bias_q[bias_bank];

   // Next-state and bus handshake decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      bus_valid = 1'b0;
      fill_done = 1'b0;
      unique case (state)
         FILL_IDLE: begin
            if (start) state_nxt = (enable && (len != '0)) ? FILL_REQ : FILL_DONE;
         end
         FILL_REQ: begin
            bus_valid = 1'b1;
            if (bus_ready && (k_q == len_q - MEM_ADDR_W'(1))) state_nxt = FILL_DONE;
         end
         FILL_DONE: begin
            fill_done = 1'b1;
            if (start) state_nxt = (enable && (len != '0)) ? FILL_REQ : FILL_DONE;
         end
         default: state_nxt = FILL_IDLE;
      endcase
   end

   // State, request address, word counter and bias capture.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state     <= FILL_IDLE;
         addr_q    <= '0;
         k_q       <= '0;
         len_q     <= '0;
         bank_q    <= 1'b0;
         bias_q[0] <= '0;
         bias_q[1] <= '0;
      end else begin
         state <= state_nxt;
         if (start && (state != FILL_REQ)) begin
            addr_q <= base;
            k_q    <= '0;
            len_q  <= len;
            bank_q <= fill_bank;
         end else if (beat) begin
            addr_q <= addr_q + STEP;
            k_q    <= k_q + MEM_ADDR_W'(1);
            if (k_q == '0) bias_q[bank_q] <= bus_rdata;
         end
      end
   end

   // Weight memory: write from the fill side, registered read for the generator.
   always_ff @(posedge clk) begin
      // NOTE: the memory array is deliberately not reset; its contents are undefined until filled.
      if (beat && !rst) mem[{bank_q, k_q[MEM_ADDR_W-2:0]}] <= bus_rdata;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/xyolo_read_mc.sv
// Multi-channel weight reader: CPU config registers, run control with ping-pong
// bank selection, per-channel fill engines, and a shared 2-D read generator.
module xyolo_read_mc
   import xyolo_read_mc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int N_CH       = 4,
   parameter int IO_ADDR_W  = 32,
   parameter int MEM_ADDR_W = 11,
   parameter int PERIOD_W   = 10
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       run,
   output logic                       done,
   input  logic                       valid,
   input  logic [3:0]                 addr,
   input  logic [IO_ADDR_W-1:0]       wdata,
   input  logic                       wstrb,
   output logic [N_CH-1:0]            databus_valid,
   input  logic [N_CH-1:0]            databus_ready,
   output logic [N_CH*IO_ADDR_W-1:0]  databus_addr,
   input  logic [N_CH*DATA_W-1:0]     databus_rdata,
   output logic [N_CH*DATA_W-1:0]     databus_wdata,
   output logic [N_CH*DATA_W/8-1:0]   databus_wstrb,
   output logic                       flow_out_valid,
   output logic [N_CH*DATA_W-1:0]     flow_out_weight,
   output logic [N_CH*DATA_W-1:0]     flow_out_bias
);

   localparam int OFF_W = offset_w(IO_ADDR_W);
   localparam int LEN_W = len_w(MEM_ADDR_W);
   localparam int RA_W  = bank_addr_w(MEM_ADDR_W);

   // Live config registers written by the CPU.
   logic [IO_ADDR_W-1:0] cfg_ext;
   logic [OFF_W-1:0]     cfg_off;
   logic [LEN_W-1:0]     cfg_len;
   logic [N_CH-1:0]      cfg_mask;
   logic [PERIOD_W-1:0]  cfg_iter, cfg_per;
   logic [RA_W-1:0]      cfg_start, cfg_shift, cfg_incr;

   // Read-side shadows held for the duration of a run.
   logic [PERIOD_W-1:0]  sh_iter, sh_per;
   logic [RA_W-1:0]      sh_shift, sh_incr;

   top_state_t           state, state_nxt;
   logic                 accept;
   logic                 bank_w, bank_r, rd_bank;
   logic                 rd_active;
   logic [PERIOD_W-1:0]  i_q, j_q;
   logic [RA_W-1:0]      row_q, ra_q;
   logic [N_CH-1:0]      fill_done;

   assign done          = (state == TOP_IDLE);
   assign accept        = run && done;
   assign databus_wdata = '0;
   assign databus_wstrb = '0;

   // CPU config writes; clear touches only these registers.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cfg_ext   <= '0;
         cfg_off   <= '0;
         cfg_len   <= '0;
         cfg_mask  <= '0;
         cfg_iter  <= '0;
         cfg_per   <= '0;
         cfg_start <= '0;
         cfg_shift <= '0;
         cfg_incr  <= '0;
      end else if (valid && wstrb) begin
         case (addr)
            CFG_EXT_ADDR: cfg_ext   <= wdata;
            CFG_OFFSET:   cfg_off   <= wdata[OFF_W-1:0];
            CFG_LEN_A:    cfg_len   <= wdata[LEN_W-1:0];
            CFG_CH_MASK:  cfg_mask  <= wdata[N_CH-1:0];
            CFG_ITER_B:   cfg_iter  <= wdata[PERIOD_W-1:0];
            CFG_PER_B:    cfg_per   <= wdata[PERIOD_W-1:0];
            CFG_START_B:  cfg_start <= wdata[RA_W-1:0];
            CFG_SHIFT_B:  cfg_shift <= wdata[RA_W-1:0];
            CFG_INCR_B:   cfg_incr  <= wdata[RA_W-1:0];
            default: ;
         endcase
      end
   end

   // Run state register.
   always_ff @(posedge clk) begin
      if (rst) state <= TOP_IDLE;
      else     state <= state_nxt;
   end

   // Run completes once every channel has filled and the generator has stopped issuing.
   always_comb begin
      state_nxt = state;
      unique case (state)
         TOP_IDLE: if (accept) state_nxt = TOP_BUSY;
         TOP_BUSY: if ((&fill_done) && !rd_active) state_nxt = TOP_IDLE;
         default:  state_nxt = TOP_IDLE;
      endcase
   end

   // Ping-pong banks: a run reads the bank the previous fill completed, fills the other.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_w  <= 1'b0;
         bank_r  <= 1'b1;
         rd_bank <= 1'b1;
      end else if (accept) begin
         rd_bank <= bank_r;
         if (cfg_len != '0) begin
            bank_w <= ~bank_w;
            bank_r <= bank_w;
         end
      end
   end

   // 2-D read generator: START + i*SHIFT + j*INCR, one address per cycle, wrapping in-bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_active      <= 1'b0;
         flow_out_valid <= 1'b0;
         sh_iter        <= '0;
         sh_per         <= '0;
         sh_shift       <= '0;
         sh_incr        <= '0;
         i_q            <= '0;
         j_q            <= '0;
         row_q          <= '0;
         ra_q           <= '0;
      end else begin
         flow_out_valid <= rd_active;
         if (accept) begin
            sh_iter   <= cfg_iter;
            sh_per    <= cfg_per;
            sh_shift  <= cfg_shift;
            sh_incr   <= cfg_incr;
            rd_active <= (cfg_iter != '0) && (cfg_per != '0);
            i_q       <= '0;
            j_q       <= '0;
            row_q     <= cfg_start;
            ra_q      <= cfg_start;
         end else if (rd_active) begin
            if (j_q == sh_per - PERIOD_W'(1)) begin
               j_q   <= '0;
               i_q   <= i_q + PERIOD_W'(1);
               row_q <= row_q + sh_shift;
               ra_q  <= row_q + sh_shift;
               if (i_q == sh_iter - PERIOD_W'(1)) rd_active <= 1'b0;
            end else begin
               j_q  <= j_q + PERIOD_W'(1);
               ra_q <= ra_q + sh_incr;
            end
         end
      end
   end

   // Channel engines. Bus ports carry channel c in slice c; flow outputs and the
   // mask carry channel 0 in the most significant position.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [IO_ADDR_W-1:0] base;
      assign base = cfg_ext + IO_ADDR_W'(c) * IO_ADDR_W'(cfg_off);

      xyolo_read_mc_ch #(
         .DATA_W     (DATA_W),
         .IO_ADDR_W  (IO_ADDR_W),
         .MEM_ADDR_W (MEM_ADDR_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .start     (accept),
         .enable    (cfg_mask[N_CH-1-c]),
         .base      (base),
         .len       (cfg_len),
         .fill_bank (bank_w),
         .bus_valid (databus_valid[c]),
         .bus_ready (databus_ready[c]),
         .bus_addr  (databus_addr[c*IO_ADDR_W +: IO_ADDR_W]),
         .bus_rdata (databus_rdata[c*DATA_W +: DATA_W]),
         .rd_en     (rd_active),
         .rd_addr   ({rd_bank, ra_q}),
         .rd_data   (flow_out_weight[(N_CH-1-c)*DATA_W +: DATA_W]),
         .bias_bank (rd_bank),
         .bias      (flow_out_bias[(N_CH-1-c)*DATA_W +: DATA_W]),
         .fill_done (fill_done[c])
      );
   end

endmodule

// File: tb/tb_xyolo_read_mc.sv
// Directed bench for xyolo_read_mc: fill addressing, ping-pong read ordering,
// bus stalls, channel masking, clear, zero-length runs and reset abort.
module tb_xyolo_read_mc;

   logic         clk = 1'b0;
   logic         rst, clear, run, done;
   logic         valid, wstrb;
   logic [3:0]   addr;
   logic [31:0]  wdata;
   logic [3:0]   databus_valid, databus_ready;
   logic [127:0] databus_addr, databus_rdata, databus_wdata;
   logic [15:0]  databus_wstrb;
   logic         flow_out_valid;
   logic [127:0] flow_out_weight, flow_out_bias;

   logic [7:0]   tag;
   int           checks = 0;
   int           errors = 0;

   // Per-run observations.
   logic [31:0]  aq [4][$];
   logic [127:0] wq [$];
   logic [3:0]   vseen;
   logic [127:0] bias0;
   logic         bias_chg;
   int           ncyc;

   xyolo_read_mc dut (
      .clk             (clk),
      .rst             (rst),
      .clear           (clear),
      .run             (run),
      .done            (done),
      .valid           (valid),
      .addr            (addr),
      .wdata           (wdata),
      .wstrb           (wstrb),
      .databus_valid   (databus_valid),
      .databus_ready   (databus_ready),
      .databus_addr    (databus_addr),
      .databus_rdata   (databus_rdata),
      .databus_wdata   (databus_wdata),
      .databus_wstrb   (databus_wstrb),
      .flow_out_valid  (flow_out_valid),
      .flow_out_weight (flow_out_weight),
      .flow_out_bias   (flow_out_bias)
   );

   always #5 clk = ~clk;

   // Bus slave: returns {tag, low 24 address bits} for whatever address is presented.
   always_comb begin
      databus_rdata = '0;
      for (int c = 0; c < 4; c++)
         databus_rdata[c*32 +: 32] = {tag, databus_addr[c*32 +: 24]};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic cfg(input logic [3:0] a, input logic [31:0] d);
      valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
      tick();
      valid = 1'b0; wstrb = 1'b0;
   endtask

   // Expected memory word k of channel c filled with tag t, base 0x1000 + c*0x100.
   function automatic logic [31:0] wd(input logic [7:0] t, input int c, input int k);
      return {t, 24'(32'h1000 + c * 32'h100 + k * 4)};
   endfunction

   // Expected flow vector, channel 0 in the most significant slice.
   function automatic logic [127:0] wexp(input logic [7:0] t0, input logic [7:0] t1,
                                         input logic [7:0] t2, input logic [7:0] t3, input int k);
      return {wd(t0, 0, k), wd(t1, 1, k), wd(t2, 2, k), wd(t3, 3, k)};
   endfunction

   // Pulse run and observe until done, optionally stalling channel 1 at random.
   task automatic do_run(input bit stall);
      logic [31:0] prev_addr;
      logic        prev_wait;
      for (int c = 0; c < 4; c++) aq[c].delete();
      wq.delete();
      vseen = '0;
      run = 1'b1;
      tick();
      run = 1'b0;
      ncyc = 0;
      prev_wait = 1'b0;
      prev_addr = '0;
      bias0 = flow_out_bias;
      bias_chg = 1'b0;
      while (1) begin
         if (stall) databus_ready[1] = 1'($urandom_range(0, 1));
         if (stall && prev_wait) begin
            check("stall_addr_stable", databus_addr[63:32], prev_addr);
            check("stall_valid_held", databus_valid[1], 1'b1);
         end
         prev_wait = databus_valid[1] && !databus_ready[1];
         prev_addr = databus_addr[63:32];
         for (int c = 0; c < 4; c++) begin
            if (databus_valid[c]) vseen[c] = 1'b1;
            if (databus_valid[c] && databus_ready[c]) aq[c].push_back(databus_addr[c*32 +: 32]);
         end
         if (flow_out_valid) wq.push_back(flow_out_weight);
         if (flow_out_bias !== bias0) bias_chg = 1'b1;
         if (done) break;
         if (ncyc == 300) begin
            check("run_timeout", done, 1'b1);
            break;
         end
         tick();
         ncyc++;
      end
      databus_ready = '1;
   endtask

   initial begin
      logic [127:0] kseq_w;
      int           kseq [4];
      rst = 1'b1; clear = 1'b0; run = 1'b0;
      valid = 1'b0; wstrb = 1'b0; addr = '0; wdata = '0;
      databus_ready = '1; tag = 8'h11;
      tick(); tick();
      check("rst_done", done, 1'b1);
      check("rst_bus_valid", databus_valid, 4'b0);
      check("rst_flow_valid", flow_out_valid, 1'b0);
      check("rst_bias", flow_out_bias, '0);
      check("wdata_zero", databus_wdata, '0);
      check("wstrb_zero", databus_wstrb, '0);
      rst = 1'b0;
      tick();

      // Run 1: fill bank 0 with tag 0x11, no reads.
      cfg(4'd0, 32'h1000);
      cfg(4'd1, 32'h100);
      cfg(4'd2, 32'd4);
      cfg(4'd3, 32'hF);
      do_run(1'b0);
      check("r1_ch2_count", aq[2].size(), 4);
      for (int k = 0; k < 4; k++)
         check("r1_ch2_addr", (k < aq[2].size()) ? aq[2][k] : 'x, 32'h1200 + k * 4);
      check("r1_ch0_first", (aq[0].size() > 0) ? aq[0][0] : 'x, 32'h1000);
      check("r1_ch3_last", (aq[3].size() > 3) ? aq[3][3] : 'x, 32'h130C);
      check("r1_latency", ncyc >= 5, 1'b1);
      check("r1_no_flow", wq.size(), 0);
      check("r1_bias", bias0, '0);

      // Run 2: read bank 0 in order 0,2,1,3 while bank 1 fills with tag 0x22.
      tag = 8'h22;
      cfg(4'd4, 32'd2);
      cfg(4'd5, 32'd2);
      cfg(4'd6, 32'd0);
      cfg(4'd7, 32'd1);
      cfg(4'd8, 32'd2);
      do_run(1'b0);
      kseq = '{0, 2, 1, 3};
      check("r2_flow_count", wq.size(), 4);
      for (int n = 0; n < 4; n++) begin
         kseq_w = wexp(8'h11, 8'h11, 8'h11, 8'h11, kseq[n]);
         check("r2_weight", (n < wq.size()) ? wq[n] : 'x, kseq_w);
      end
      check("r2_bias", bias0, wexp(8'h11, 8'h11, 8'h11, 8'h11, 0));
      check("r2_bias_stable", bias_chg, 1'b0);
      check("r2_ch1_fill_count", aq[1].size(), 4);

      // Run 3: fill bank 0 with tag 0x33 under random stalls on channel 1.
      tag = 8'h33;
      cfg(4'd4, 32'd0);
      do_run(1'b1);
      check("r3_ch1_count", aq[1].size(), 4);
      for (int k = 0; k < 4; k++)
         check("r3_ch1_order", (k < aq[1].size()) ? aq[1][k] : 'x, 32'h1100 + k * 4);
      check("r3_bias", bias0, wexp(8'h22, 8'h22, 8'h22, 8'h22, 0));

      // Run 4: mask 1010 enables ch0/ch2 only; read bank 0 linearly.
      tag = 8'h44;
      cfg(4'd3, 32'hA);
      cfg(4'd4, 32'd1);
      cfg(4'd5, 32'd4);
      cfg(4'd7, 32'd0);
      cfg(4'd8, 32'd1);
      do_run(1'b0);
      check("r4_masked_valid", {vseen[3], vseen[1]}, 2'b00);
      check("r4_enabled_valid", {vseen[2], vseen[0]}, 2'b11);
      check("r4_flow_count", wq.size(), 4);
      for (int n = 0; n < 4; n++)
         check("r4_weight", (n < wq.size()) ? wq[n] : 'x, wexp(8'h33, 8'h33, 8'h33, 8'h33, n));
      check("r4_bias", bias0, wexp(8'h33, 8'h33, 8'h33, 8'h33, 0));

      // Run 5: clear zeroes LEN_A, so no fill; reads bank 1 (ch1/ch3 kept tag 0x22).
      tag = 8'h55;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      cfg(4'd4, 32'd1);
      cfg(4'd5, 32'd4);
      cfg(4'd8, 32'd1);
      do_run(1'b0);
      check("r5_no_bus", vseen, 4'b0);
      check("r5_flow_count", wq.size(), 4);
      for (int n = 0; n < 4; n++)
         check("r5_weight", (n < wq.size()) ? wq[n] : 'x, wexp(8'h44, 8'h22, 8'h44, 8'h22, n));
      check("r5_bias", bias0, wexp(8'h44, 8'h22, 8'h44, 8'h22, 0));

      // Run 6: another zero-length run leaves the read bank where it was.
      do_run(1'b0);
      check("r6_no_bus", vseen, 4'b0);
      check("r6_weight_last", (wq.size() > 3) ? wq[3] : 'x, wexp(8'h44, 8'h22, 8'h44, 8'h22, 3));

      // Run 7: run while busy is ignored, then reset aborts the fill.
      cfg(4'd0, 32'h1000);
      cfg(4'd1, 32'h100);
      cfg(4'd2, 32'd4);
      cfg(4'd3, 32'hF);
      cfg(4'd4, 32'd0);
      run = 1'b1;
      tick();
      run = 1'b0;
      check("r7_addr0", databus_addr[31:0], 32'h1000);
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      check("r7_busy", done, 1'b0);
      check("r7_run_ignored", databus_addr[31:0], 32'h1008);
      rst = 1'b1;
      tick();
      check("r7_rst_done", done, 1'b1);
      check("r7_rst_valid", databus_valid, 4'b0);
      check("r7_rst_flow", flow_out_valid, 1'b0);
      rst = 1'b0;
      tick();
      check("r7_post_valid", databus_valid, 4'b0);
      check("r7_post_done", done, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xyolo_read_mc.md
XYOLO_READ_MC -- requirements
Module: xyolo_read_mc

Interface
REQ-001 Parameter DATA_W, 32, data word width (multiple of 8).
REQ-002 Parameter N_CH, 4, number of weight channels.
REQ-003 Parameter IO_ADDR_W, 32, external byte-address width.
REQ-004 Parameter MEM_ADDR_W, 11, internal memory address width; MSB is bank select.
REQ-005 Parameter PERIOD_W, 10, period counter width.
REQ-006 Ports: clk in 1, clock; rst in 1, reset; one clock, reset synchronous and active-high.
REQ-007 Ports: clear in 1, clear config; run in 1, start pulse; done out 1, idle.
REQ-008 Ports: valid in 1, addr in 4, wdata in IO_ADDR_W, wstrb in 1 — CPU config write, accepted when valid&wstrb.
REQ-009 Ports: databus_valid out N_CH; databus_ready in N_CH; databus_addr out N_CH*IO_ADDR_W; databus_rdata in N_CH*DATA_W; databus_wdata out N_CH*DATA_W (0); databus_wstrb out N_CH*DATA_W/8 (0).
REQ-010 Ports: flow_out_valid out 1; flow_out_weight out N_CH*DATA_W; flow_out_bias out N_CH*DATA_W; channel 0 in MS slice.

Function
REQ-011 Config map: 0 EXT_ADDR, 1 OFFSET (IO_ADDR_W/2 bits), 2 LEN_A, 3 CH_MASK (N_CH bits, 1=enabled), 4 ITER_B, 5 PER_B, 6 START_B, 7 SHIFT_B, 8 INCR_B; other addresses ignored.
REQ-012 run SHALL be accepted only when done=1; run while busy SHALL be ignored; accepted run latches all config into shadow registers same cycle and drops done next cycle.
REQ-013 Channel c base address SHALL be EXT_ADDR + c*OFFSET, truncated to IO_ADDR_W.
REQ-014 Fill: each enabled channel issues LEN_A reads at base + k*(DATA_W/8), k=0..LEN_A-1, one outstanding, valid held with stable addr until ready; word k written to mem[bank_w][k] on the ready cycle.
REQ-015 Word 0 of each channel SHALL also be captured into that channel's bias register for bank_w.
REQ-016 Masked channel: databus_valid stays 0, memory and bias of that channel unchanged, counts as fill-complete immediately.
REQ-017 Read generator: for i<ITER_B, j<PER_B, one address per cycle = START_B + i*SHIFT_B + j*INCR_B mod 2^(MEM_ADDR_W-1), MSB = bank_r; all channels read same address.
REQ-018 flow_out_valid and flow_out_weight SHALL appear 1 cycle after the read address (memory latency 1); flow_out_bias SHALL show bias of bank_r, stable for whole run.
REQ-019 Ping-pong: bank_r = bank completed by previous fill; bank_w toggles at each accepted run with LEN_A!=0; fill and read of one run proceed concurrently on opposite banks.
REQ-020 ITER_B=0 or PER_B=0: no reads, read side complete immediately; LEN_A=0: no fill, no bank toggle.
REQ-021 done SHALL rise the cycle after all channels fill-complete and last flow_out_valid issued.
REQ-022 clear resets config registers only; shadows, banks, memory, and an in-progress run unaffected.

Reset
REQ-023 On rst: done=1, databus_valid=0, flow_out_valid=0, config and shadow=0, bank_w=0, bank_r=1, biases=0; memory contents undefined.
REQ-024 rst mid-run aborts immediately; next cycle module idle, no further bus requests.

Structure
REQ-025 Config address constants and field widths in shared package xyolo_read_mc_pkg.
REQ-026 One sub-module xyolo_read_mc_ch (fill FSM IDLE/REQ/DONE, 2-bank memory, bias regs) instantiated N_CH times; read generator in top.

Verification
REQ-027 Fill N_CH=4, EXT_ADDR=0x1000, OFFSET=0x100, LEN_A=4, ready always 1 -> ch2 reads 0x1200,0x1204,0x1208,0x120C; done after ≥5 cycles.
REQ-028 Second run ITER_B=2, PER_B=2, START_B=0, SHIFT_B=1, INCR_B=2 -> read addrs 0,2,1,3 of bank 0; flow_out_bias = first-run word 0.
REQ-029 Random ready stalls on ch1 -> databus_addr stable while valid&!ready, memory order preserved.
REQ-030 CH_MASK=4'b1010 -> ch1,ch3 never assert valid; their bias unchanged.
REQ-031 run pulsed while busy, then rst mid-fill -> run ignored; after rst done=1, valid=0.
REQ-032 LEN_A=0 run -> no bus activity, bank_r unchanged, reads from old bank.
